// File: rtl/lc_pkg.sv
// lc_pkg: shared constants for the latency counter register block.
// Register offsets, CTRL field positions and AXI response codes.
package lc_pkg;

  localparam logic [3:0] LC_REG_CTRL     = 4'h0;
  localparam logic [3:0] LC_REG_TADDR    = 4'h4;
  localparam logic [3:0] LC_REG_LAT_LAST = 4'h8;
  localparam logic [3:0] LC_REG_LAT_MAX  = 4'hC;

  localparam int LC_CTRL_START   = 0;
  localparam int LC_CTRL_CLEAR   = 1;
  localparam int LC_CTRL_BLEN_LO = 8;

  localparam logic [1:0] LC_RESP_OKAY   = 2'b00;
  localparam logic [1:0] LC_RESP_SLVERR = 2'b10;

  // Word offset from the register-select bits; low bits alias.
  function automatic logic [3:0] lc_reg_off(
    input logic [1:0] sel
  );
    return {sel, 2'b00};
  endfunction

endpackage

// File: rtl/lc_axil_regs_if.sv
// lc_axil_regs_if: AXI4-Lite bundle for the latency counter registers.
// master drives requests, slave drives responses.
interface lc_axil_regs_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/lc_axil_wr_hold.sv
// lc_axil_wr_hold: one-entry holding register for an AXI write channel.
// have/data bypass the incoming beat so a commit can use it at once.
module lc_axil_wr_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         take,
  output logic         have,
  output logic [W-1:0] data
);

  logic         full;
  logic [W-1:0] q;

  assign in_ready = ~full & ~rst;
  assign have     = full | (in_valid & in_ready);
  assign data     = full ? q : in_data;

  // Capture on handshake; a commit frees the entry (stored or bypassed).
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (take) begin
      full <= 1'b0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      q    <= in_data;
    end
  end

endmodule

// File: rtl/lc_axil_regs.sv
// lc_axil_regs: AXI4-Lite register file for the latency counter core.
// Define LC_AXIL_SLVERR_EN to answer writes to RO registers with SLVERR.
module lc_axil_regs
  import lc_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_areset,
  lc_axil_regs_if.slave s00_axi,
  output logic        start_pulse,
  output logic        clear_pulse,
  output logic [7:0]  burst_len,
  output logic [31:0] target_addr,
  input  logic        lat_valid,
  input  logic [31:0] lat_value
);

  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int AW = C_S00_AXI_ADDR_WIDTH;

  logic clk;
  logic rst;
  assign clk = s00_axi_aclk;
  assign rst = s00_axi_areset;

  logic          aw_have;
  logic [AW-1:0] aw_data;
  logic          w_have;
  logic [DW+DW/8-1:0] w_data;
  logic          commit;
  logic [3:0]    wr_off;
  logic [3:0]    wr_strb;
  logic [31:0]   wr_data;
  logic [1:0]    wr_resp;

  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          rvalid_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rd_mux;
  logic [3:0]    rd_off;
  logic          ar_hs;

  logic [7:0]    blen_q;
  logic [31:0]   taddr_q;
  logic [31:0]   lat_last_q;
  logic [31:0]   lat_max_q;
  logic          start_q;
  logic          clear_q;

  lc_axil_wr_hold #(.W(AW)) u_aw_hold (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s00_axi.awvalid),
    .in_ready (s00_axi.awready),
    .in_data  (s00_axi.awaddr),
    .take     (commit),
    .have     (aw_have),
    .data     (aw_data)
  );

  lc_axil_wr_hold #(.W(DW + DW/8)) u_w_hold (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s00_axi.wvalid),
    .in_ready (s00_axi.wready),
    .in_data  ({s00_axi.wstrb, s00_axi.wdata}),
    .take     (commit),
    .have     (w_have),
    .data     (w_data)
  );

  assign commit  = aw_have & w_have & ~bvalid_q;
  assign wr_off  = lc_reg_off(aw_data[3:2]);
  assign wr_strb = w_data[DW +: 4];
  assign wr_data = w_data[31:0];

`ifdef LC_AXIL_SLVERR_EN
  assign wr_resp = (wr_off == LC_REG_LAT_LAST ||
                    wr_off == LC_REG_LAT_MAX)
                   ? LC_RESP_SLVERR : LC_RESP_OKAY;
`else
  assign wr_resp = LC_RESP_OKAY;
`endif

  // Register writes with byte enables; CTRL start/clear become pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      blen_q  <= '0;
      taddr_q <= '0;
      start_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      start_q <= commit && wr_off == LC_REG_CTRL &&
                 wr_strb[0] && wr_data[LC_CTRL_START];
      clear_q <= commit && wr_off == LC_REG_CTRL &&
                 wr_strb[0] && wr_data[LC_CTRL_CLEAR];
      if (commit && wr_off == LC_REG_CTRL && wr_strb[1])
        blen_q <= wr_data[LC_CTRL_BLEN_LO +: 8];
      if (commit && wr_off == LC_REG_TADDR)
        for (int i = 0; i < 4; i++)
          if (wr_strb[i])
            taddr_q[8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Write response: raised after commit, held until bready.
  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= LC_RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_resp;
    end else if (s00_axi.bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // Latency stats; a clear drops any sample arriving with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_last_q <= '0;
      lat_max_q  <= '0;
    end else if (clear_q) begin
      lat_last_q <= '0;
      lat_max_q  <= '0;
    end else if (lat_valid) begin
      lat_last_q <= lat_value;
      if (lat_value > lat_max_q)
        lat_max_q <= lat_value;
    end
  end

  assign ar_hs  = s00_axi.arvalid & s00_axi.arready;
  assign rd_off = lc_reg_off(s00_axi.araddr[3:2]);

  // Read decode from current (pre-update) register values.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      rd_off == LC_REG_CTRL:     rd_mux = {16'h0, blen_q, 8'h0};
      rd_off == LC_REG_TADDR:    rd_mux = taddr_q;
      rd_off == LC_REG_LAT_LAST: rd_mux = lat_last_q;
      rd_off == LC_REG_LAT_MAX:  rd_mux = lat_max_q;
      default:                   rd_mux = '0;
    endcase
  end

  // Read data channel: one outstanding response, held until rready.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
    end else if (s00_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s00_axi.arready = ~rvalid_q & ~rst;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = LC_RESP_OKAY;

  assign start_pulse = start_q;
  assign clear_pulse = clear_q;
  assign burst_len   = blen_q;
  assign target_addr = taddr_q;

  logic unused_bits;
  assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                         aw_data, s00_axi.araddr, w_data};

endmodule

// File: tb/tb_lc_axil_regs.sv
// tb_lc_axil_regs: directed bench with a register-map model and scoreboard.
// Responses are checked as bvalid rises; outputs are compared each cycle.
`timescale 1ns/1ps
module tb_lc_axil_regs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lc_axil_regs_if #(.ADDR_W(4), .DATA_W(32)) axi ();

  logic        start_pulse;
  logic        clear_pulse;
  logic [7:0]  burst_len;
  logic [31:0] target_addr;
  logic        lat_valid;
  logic [31:0] lat_value;

  lc_axil_regs #(
    .C_S00_AXI_DATA_WIDTH(32),
    .C_S00_AXI_ADDR_WIDTH(4)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .s00_axi        (axi),
    .start_pulse    (start_pulse),
    .clear_pulse    (clear_pulse),
    .burst_len      (burst_len),
    .target_addr    (target_addr),
    .lat_valid      (lat_valid),
    .lat_value      (lat_value)
  );

`ifdef LC_AXIL_SLVERR_EN
  localparam logic [1:0] RO_RESP = 2'b10;
`else
  localparam logic [1:0] RO_RESP = 2'b00;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0]  m_blen;
  logic [31:0] m_taddr;
  logic [31:0] m_last;
  logic [31:0] m_max;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;
  wr_t wq[$];

  int start_cyc = 0;
  int clear_cyc = 0;
  bit run_chk = 0;
  logic [31:0] got;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {16'h0, m_blen, 8'h0};
      2'd1:    return m_taddr;
      2'd2:    return m_last;
      default: return m_max;
    endcase
  endfunction

  task automatic model_wr(input wr_t w, output logic [1:0] resp,
                          output logic st, output logic cl);
    st = 0;
    cl = 0;
    resp = 2'b00;
    case (w.a[3:2])
      2'd0: begin
        if (w.s[1]) m_blen = w.d[15:8];
        st = w.s[0] & w.d[0];
        cl = w.s[0] & w.d[1];
      end
      2'd1:
        for (int i = 0; i < 4; i++)
          if (w.s[i]) m_taddr[8*i +: 8] = w.d[8*i +: 8];
      default: resp = RO_RESP;
    endcase
  endtask

  // Scoreboard: each new write response is matched to the oldest write.
  logic prev_bv = 0;
  always begin
    wr_t w;
    logic [1:0] r;
    logic st, cl;
    @(posedge clk);
    #2;
    if (rst) begin
      prev_bv = 0;
      wq.delete();
    end else begin
      if (axi.bvalid && !prev_bv) begin
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bvalid: got unexpected response, required none");
        end else begin
          w = wq.pop_front();
          model_wr(w, r, st, cl);
          chk("bresp", axi.bresp, r);
          chk("start_pulse", start_pulse, st);
          chk("clear_pulse", clear_pulse, cl);
          if (cl) begin
            m_last = 0;
            m_max = 0;
          end
        end
      end
      prev_bv = axi.bvalid;
    end
  end

  // Per-cycle compare of configuration outputs and pulse width.
  logic prev_st = 0;
  logic prev_cl = 0;
  always @(negedge clk) begin
    if (!rst && run_chk) begin
      chk("burst_len", burst_len, m_blen);
      chk("target_addr", target_addr, m_taddr);
      chk("pulse_width", {prev_st & start_pulse, prev_cl & clear_pulse}, 0);
      if (axi.rvalid) chk("rresp", axi.rresp, 2'b00);
      if (start_pulse) start_cyc++;
      if (clear_pulse) clear_cyc++;
    end
    prev_st = start_pulse;
    prev_cl = clear_pulse;
  end

  task automatic send_wr(input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int w_lead);
    bit aw_done = 0;
    bit w_done = 0;
    bit hs_aw, hs_w;
    int n = 0;
    wr_t e;
    e.a = a;
    e.d = d;
    e.s = s;
    axi.wdata = d;
    axi.wstrb = s;
    axi.awaddr = a;
    axi.wvalid = 1;
    while (!(aw_done && w_done) && n < 64) begin
      if (!aw_done && n >= w_lead) axi.awvalid = 1;
      @(negedge clk);
      hs_aw = axi.awvalid & axi.awready;
      hs_w = axi.wvalid & axi.wready;
      @(posedge clk);
      if (hs_aw) aw_done = 1;
      if (hs_w) w_done = 1;
      if (aw_done && w_done) wq.push_back(e);
      #1;
      if (hs_aw) axi.awvalid = 0;
      if (hs_w) axi.wvalid = 0;
      n++;
    end
    if (!(aw_done && w_done)) begin
      checks++;
      failures++;
      $display("FAIL wr_handshake: got timeout, required accept");
      axi.awvalid = 0;
      axi.wvalid = 0;
    end
  endtask

  task automatic wait_b();
    int n = 0;
    while (n < 64) begin
      @(negedge clk);
      if (axi.bvalid && axi.bready) break;
      n++;
    end
    if (n >= 64) begin
      checks++;
      failures++;
      $display("FAIL b_handshake: got timeout, required bvalid");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_rd(input logic [3:0] a, input string nm,
                       output logic [31:0] val);
    logic [31:0] exp;
    bit hs = 0;
    int n = 0;
    exp = '0;
    axi.araddr = a;
    axi.arvalid = 1;
    while (!hs && n < 64) begin
      @(negedge clk);
      hs = axi.arready;
      if (hs) exp = model_rd(a);
      @(posedge clk);
      #1;
      n++;
    end
    axi.arvalid = 0;
    val = axi.rdata;
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL %s: got arready timeout, required accept", nm);
    end else begin
      chk({nm, "_rvalid"}, axi.rvalid, 1);
      chk(nm, axi.rdata, exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lat(input logic [31:0] v);
    lat_value = v;
    lat_valid = 1;
    @(posedge clk);
    #1;
    lat_valid = 0;
    m_last = v;
    if (v > m_max) m_max = v;
  endtask

  initial begin
    axi.awaddr = 0; axi.awprot = 0; axi.awvalid = 0;
    axi.wdata = 0; axi.wstrb = 0; axi.wvalid = 0;
    axi.bready = 1;
    axi.araddr = 0; axi.arprot = 0; axi.arvalid = 0;
    axi.rready = 1;
    lat_valid = 0; lat_value = 0;
    m_blen = 0; m_taddr = 0; m_last = 0; m_max = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", axi.awready, 0);
    chk("rst_wready", axi.wready, 0);
    chk("rst_arready", axi.arready, 0);
    chk("rst_bvalid", axi.bvalid, 0);
    chk("rst_rvalid", axi.rvalid, 0);
    chk("rst_pulses", {start_pulse, clear_pulse}, 0);
    chk("rst_blen", burst_len, 0);
    chk("rst_taddr", target_addr, 0);
    @(posedge clk);
    #1;
    rst = 0;
    run_chk = 1;
    @(negedge clk);
    chk("up_readies", {axi.awready, axi.wready, axi.arready}, 3'b111);
    @(posedge clk);
    #1;

    // CTRL start + burst length
    send_wr(4'h0, 32'h0000_1201, 4'hF, 0);
    wait_b();
    repeat (2) @(posedge clk);
    #1;
    chk("start_count", start_cyc, 1);
    chk("blen_lit", burst_len, 8'h12);
    do_rd(4'h0, "rd_ctrl", got);
    chk("rd_ctrl_lit", got, 32'h0000_1200);

    // TADDR byte enables
    send_wr(4'h4, 32'h0, 4'hF, 0);
    wait_b();
    send_wr(4'h5, 32'hDEAD_BEEF, 4'b0011, 0);
    wait_b();
    do_rd(4'h6, "rd_taddr", got);
    chk("rd_taddr_lit", got, 32'h0000_BEEF);

    // W three cycles ahead of AW
    send_wr(4'h4, 32'hCAFE_0123, 4'hF, 3);
    chk("b_after_aw", axi.bvalid, 1);
    wait_b();
    repeat (3) @(posedge clk);
    #1;
    chk("single_commit", axi.bvalid, 0);
    chk("taddr_lit", target_addr, 32'hCAFE_0123);

    // Statistics
    lat(50);
    lat(20);
    do_rd(4'h8, "rd_last1", got);
    chk("last1_lit", got, 20);
    do_rd(4'hC, "rd_max1", got);
    chk("max1_lit", got, 50);
    lat(80);
    do_rd(4'h8, "rd_last2", got);
    chk("last2_lit", got, 80);
    do_rd(4'hC, "rd_max2", got);
    chk("max2_lit", got, 80);

    // Clear in the cycle a sample arrives
    fork
      send_wr(4'h0, 32'h2, 4'hF, 0);
      lat(99);
    join
    wait_b();
    repeat (2) @(posedge clk);
    #1;
    chk("clear_count", clear_cyc, 1);
    do_rd(4'h8, "rd_last_clr", got);
    chk("last_clr_lit", got, 0);
    do_rd(4'hC, "rd_max_clr", got);
    chk("max_clr_lit", got, 0);

    // Read and write of TADDR in the same cycle
    fork
      send_wr(4'h4, 32'h55AA_55AA, 4'hF, 0);
      do_rd(4'h4, "rd_same_wr", got);
    join
    chk("same_wr_lit", got, 32'hCAFE_0123);
    repeat (3) @(posedge clk);
    #1;
    do_rd(4'h4, "rd_after_wr", got);
    chk("after_wr_lit", got, 32'h55AA_55AA);

    // Read of LAT_LAST in the cycle a sample arrives
    fork
      lat(123);
      do_rd(4'h8, "rd_same_lat", got);
    join
    chk("same_lat_lit", got, 0);
    do_rd(4'h8, "rd_lat123", got);
    chk("lat123_lit", got, 123);

    // B backpressure
    axi.bready = 0;
    send_wr(4'h4, 32'h1111_1111, 4'hF, 0);
    send_wr(4'h4, 32'h2222_2222, 4'hF, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_readies", {axi.awready, axi.wready}, 0);
      chk("bp_bvalid", axi.bvalid, 1);
    end
    chk("bp_taddr_lit", target_addr, 32'h1111_1111);
    @(posedge clk);
    #1;
    axi.bready = 1;
    wait_b();
    wait_b();
    do_rd(4'h4, "rd_bp", got);
    chk("bp_lit", got, 32'h2222_2222);

    // Write to a read-only register
    send_wr(4'h8, 32'hFFFF_FFFF, 4'hF, 0);
    chk("ro_bresp_lit", axi.bresp, RO_RESP);
    wait_b();
    do_rd(4'h8, "rd_ro", got);
    chk("ro_lit", got, 123);

    // Reset with an AW parked in its holder
    axi.awaddr = 4'h0;
    axi.awvalid = 1;
    @(posedge clk);
    #1;
    axi.awvalid = 0;
    rst = 1;
    m_blen = 0; m_taddr = 0; m_last = 0; m_max = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    axi.wdata = 32'h1;
    axi.wstrb = 4'hF;
    axi.wvalid = 1;
    @(posedge clk);
    #1;
    axi.wvalid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_commit", {axi.bvalid, start_pulse}, 0);
    end
    @(posedge clk);
    #1;
    wq.push_back(wr_t'{a: 4'h4, d: 32'h1, s: 4'hF});
    axi.awaddr = 4'h4;
    axi.awvalid = 1;
    @(posedge clk);
    #1;
    axi.awvalid = 0;
    wait_b();
    chk("rst_taddr_lit", target_addr, 32'h1);
    chk("rst_start_total", start_cyc, 1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
